eth_rx_ring: RTL

//  Parametrised multi-slot receive buffer manager for the Ethernet controller.

---
 rtl/eth_rx_ring_pkg.sv | 22 ++
 rtl/eth_slot_alloc.sv | 51 +++++
 rtl/eth_rx_ring.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_ring_pkg.sv
// eth_rx_ring_pkg: shared definitions for the multi-slot receive ring.
//   - FSM state encodings (fixed values, kept compatible with the legacy encoding)
//   - error bit positions inside the 4-bit per-slot status word
//   - saturating 16-bit increment used by the drop counter
package eth_rx_ring_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECV    = 3'd1;
  localparam logic [2:0] ST_FLUSH   = 3'd2;
  localparam logic [2:0] ST_CLOSE   = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  localparam int unsigned ERR_CRC  = 0;
  localparam int unsigned ERR_RXER = 1;
  localparam int unsigned ERR_OVF  = 2;
  localparam int unsigned ERR_RUNT = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_slot_alloc.sv
// eth_slot_alloc: slot ownership bookkeeping for the receive ring.
//   clk, rst   : clock, synchronous active-high reset
//   commit     : mark slot at ptr full and advance ptr (frame posted)
//   rel        : host release strobe for rel_slot
//   filling    : a frame is currently being written into slot ptr
//   full       : per-slot full bitmap
//   ptr        : round-robin write pointer
//   ptr_free   : slot at ptr may be allocated
//   free_cnt   : number of free slots, net of same-cycle commit and release
module eth_slot_alloc #(
  parameter  int unsigned NSLOT = 4,
  localparam int unsigned SW    = $clog2(NSLOT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic             rel,
  input  logic [SW-1:0]    rel_slot,
  input  logic             filling,
  output logic [NSLOT-1:0] full,
  output logic [SW-1:0]    ptr,
  output logic             ptr_free,
  output logic [SW:0]      free_cnt
);

  logic rel_ok;

  // A release only counts when it frees something: the slot must hold a
  // frame and must not be the one the receiver is writing into.
  always_comb begin
    rel_ok = rel && full[rel_slot] && !(filling && (rel_slot == ptr));
  end

  assign ptr_free = ~full[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= '0;
      ptr      <= '0;
      free_cnt <= (SW+1)'(NSLOT);
    end else begin
      if (rel_ok) full[rel_slot] <= 1'b0;
      if (commit) begin
        full[ptr] <= 1'b1;
        ptr       <= ptr + SW'(1);  // NSLOT is a power of two, so this wraps
      end
      free_cnt <= free_cnt + (SW+1)'(rel_ok) - (SW+1)'(commit);
    end
  end

endmodule

// File: rtl/eth_rx_ring.sv
// eth_rx_ring: multi-slot receive buffer manager.
// Packs received bytes into 16-bit words, writes them into one of NSLOT ring
// slots and posts per-slot length/error status; the host frees slots.
//   clk_i, rst_i                 : receive clock, synchronous active-high reset
//   rx_ena_i, rxdv_i, rxer_i     : receive enable, byte valid, receive error
//   rxd_i                        : received byte
//   crc_good_i                   : CRC good, valid in the first rxdv_i=0 cycle
//   mem_addr_o/mem_data_o        : buffer address {slot, word} and write data
//   mem_wrn_o                    : active-low write strobe
//   rel_i, rel_slot_i            : host release of a slot
//   stat_slot_i                  : status read select
//   stat_len_o/err_o/full_o      : status of the selected slot (combinational)
//   done_o, done_slot_o          : frame posted pulse and its slot
//   free_cnt_o, drop_cnt_o       : free slots, dropped frames (saturating)
//   busy_o                       : FSM not idle
module eth_rx_ring
  import eth_rx_ring_pkg::*;
#(
  parameter  int unsigned NSLOT  = 4,
  parameter  int unsigned AW     = 10,
  parameter  int unsigned MINLEN = 60,
  localparam int unsigned SW     = $clog2(NSLOT)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx_ena_i,
  input  logic           rxdv_i,
  input  logic           rxer_i,
  input  logic [7:0]     rxd_i,
  input  logic           crc_good_i,
  output logic [SW+AW-1:0] mem_addr_o,
  output logic [15:0]    mem_data_o,
  output logic           mem_wrn_o,
  input  logic           rel_i,
  input  logic [SW-1:0]  rel_slot_i,
  input  logic [SW-1:0]  stat_slot_i,
  output logic [AW+1:0]  stat_len_o,
  output logic [3:0]     stat_err_o,
  output logic           stat_full_o,
  output logic           done_o,
  output logic [SW-1:0]  done_slot_o,
  output logic [SW:0]    free_cnt_o,
  output logic [15:0]    drop_cnt_o,
  output logic           busy_o
);

  localparam logic [AW+1:0] CAP = {1'b1, {(AW+1){1'b0}}};

  logic [2:0]       state;
  logic             rxdv_q;
  logic [AW+1:0]    cnt;
  logic [7:0]       lo_byte;
  logic             ovf, rxer_acc, crc_bad, mid_new;
  logic             wrn_q;
  logic [SW+AW-1:0] addr_q;
  logic [15:0]      data_q;
  logic [15:0]      drop_q;
  logic [AW+1:0]    len_r [NSLOT];
  logic [3:0]       err_r [NSLOT];

  logic [NSLOT-1:0] full;
  logic [SW-1:0]    ptr;
  logic             ptr_free;
  logic             rise, commit, filling;
  logic [3:0]       err_new;

  always_comb begin
    rise    = rxdv_i && !rxdv_q;
    commit  = (state == ST_CLOSE);
    filling = (state == ST_RECV) || (state == ST_FLUSH) || (state == ST_CLOSE);
    err_new           = '0;
    err_new[ERR_CRC]  = crc_bad;
    err_new[ERR_RXER] = rxer_acc;
    err_new[ERR_OVF]  = ovf;
    err_new[ERR_RUNT] = (32'(cnt) < MINLEN);
  end

  eth_slot_alloc #(.NSLOT(NSLOT)) u_alloc (
    .clk      (clk_i),
    .rst      (rst_i),
    .commit   (commit),
    .rel      (rel_i),
    .rel_slot (rel_slot_i),
    .filling  (filling),
    .full     (full),
    .ptr      (ptr),
    .ptr_free (ptr_free),
    .free_cnt (free_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      // Held high so a frame already in flight across reset is not mistaken
      // for a new start of frame.
      rxdv_q   <= 1'b1;
      cnt      <= '0;
      lo_byte  <= '0;
      ovf      <= 1'b0;
      rxer_acc <= 1'b0;
      crc_bad  <= 1'b0;
      mid_new  <= 1'b0;
      wrn_q    <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        len_r[i] <= '0;
        err_r[i] <= '0;
      end
    end else begin
      rxdv_q <= rxdv_i;
      wrn_q  <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            if (!rx_ena_i) begin
              state <= ST_DISCARD;
            end else if (!ptr_free) begin
              state  <= ST_DISCARD;
              drop_q <= sat_inc16(drop_q);
            end else begin
              state    <= ST_RECV;
              cnt      <= (AW+2)'(1);
              lo_byte  <= rxd_i;
              ovf      <= 1'b0;
              rxer_acc <= rxer_i;
              mid_new  <= 1'b0;
            end
          end
        end
        ST_RECV: begin
          if (rxdv_i) begin
            rxer_acc <= rxer_acc | rxer_i;
            if (cnt == CAP) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + (AW+2)'(1);
              // cnt is the index of this byte; odd index completes a word
              if (cnt[0]) begin
                wrn_q  <= 1'b0;
                addr_q <= {ptr, cnt[AW:1]};
                data_q <= {rxd_i, lo_byte};
              end else begin
                lo_byte <= rxd_i;
              end
            end
          end else begin
            crc_bad <= ~crc_good_i;
            if (cnt[0]) begin
              wrn_q  <= 1'b0;
              addr_q <= {ptr, cnt[AW:1]};
              data_q <= {8'h00, lo_byte};
              state  <= ST_FLUSH;
            end else begin
              state <= ST_CLOSE;
            end
          end
        end
        ST_FLUSH: begin
          if (rxdv_i) mid_new <= 1'b1;
          state <= ST_CLOSE;
        end
        ST_CLOSE: begin
          len_r[ptr] <= cnt;
          err_r[ptr] <= err_new;
          if (rxdv_i || mid_new) begin
            state  <= ST_DISCARD;
            drop_q <= sat_inc16(drop_q);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (!rxdv_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign mem_wrn_o   = wrn_q;
  assign done_o      = commit;
  assign done_slot_o = ptr;
  assign drop_cnt_o  = drop_q;
  assign busy_o      = (state != ST_IDLE);
  assign stat_len_o  = len_r[stat_slot_i];
  assign stat_err_o  = err_r[stat_slot_i];
  assign stat_full_o = full[stat_slot_i];

endmodule
